// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the simple-CPU control sequencer: opcodes, states, field positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_ctrl_pkg;

  // Opcode encodings; 3..6 are illegal
  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVI = 3'd1;
  localparam logic [2:0] OP_ALU = 3'd2;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  // Bit positions in the register-enable and bus-driver vectors
  localparam int REG_G_IDX   = 9;
  localparam int REG_A_IDX   = 10;
  localparam int TRI_G_IDX   = 9;
  localparam int TRI_IMM_IDX = 10;

  // Instruction word field positions
  localparam int OPC_LSB  = 29;
  localparam int RX_LSB   = 26;
  localparam int RY_LSB   = 23;
  localparam int ALU_LSB  = 20;
  localparam int RSVD_LSB = 16;
  localparam int RSVD_W   = 4;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 16;

endpackage

// File: rtl/cpu_ctrl_seq_onehot_dec.sv
// 3-bit index to 8-bit one-hot decoder with enable; all-zero when disabled.
// Latency: combinational.
// Backpressure: none.
module onehot_dec (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] oh
);

  // Set only the addressed bit, and only when enabled
  always_comb begin
    oh = '0;
    if (en) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle sequencer: latches an instruction on run in IDLE and steps T1..T3 driving bus enables.
// Latency: done 1 cycle after the run-sampling edge for MV/MVI/NOP, 3 cycles for ALU.
// Backpressure: run ignored while busy; requester waits for busy=0. Option: CPU_CTRL_ILLEGAL_TRAP_EN.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int EN_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [31:0]       instr,
  output logic [EN_W-1:0]   r_en_OH,
  output logic [EN_W-1:0]   tri_controller_OH,
  output logic [22:0]       code,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state, state_nxt;

  // Latched instruction fields; the reserved nibble is never stored
  logic [2:0]       ir_op, ir_rx, ir_ry, ir_alu;
  logic [IMM_W-1:0] ir_imm;
  logic [ADDR_W-1:0] addr_q;

  // Step controls decoded from state + IR
  logic ld_rx, ld_a, ld_g;
  logic drv_en, drv_sel_rx, drv_g, drv_imm;
  logic done_c;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic trap;
  logic err_q;
`endif

  logic [2:0] drv_idx;
  logic [7:0] rx_oh, drv_oh;

  logic unused_rsvd;
  assign unused_rsvd = ^instr[RSVD_LSB +: RSVD_W];

  // State, IR and address counter; synchronous reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ir_op  <= '0;
      ir_rx  <= '0;
      ir_ry  <= '0;
      ir_alu <= '0;
      ir_imm <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && run) begin
        ir_op  <= instr[OPC_LSB +: 3];
        ir_rx  <= instr[RX_LSB  +: 3];
        ir_ry  <= instr[RY_LSB  +: 3];
        ir_alu <= instr[ALU_LSB +: 3];
        ir_imm <= instr[IMM_LSB +: IMM_W];
      end
      if (done_c) addr_q <= addr_q + 1'b1;
    end
  end

  // Next-state and per-step enable selection
  always_comb begin
    state_nxt  = state;
    ld_rx      = 1'b0;
    ld_a       = 1'b0;
    ld_g       = 1'b0;
    drv_en     = 1'b0;
    drv_sel_rx = 1'b0;
    drv_g      = 1'b0;
    drv_imm    = 1'b0;
    done_c     = 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_T1;
      end
      ST_T1: begin
        state_nxt = ST_IDLE;
        case (ir_op)
          OP_MV: begin
            drv_en = 1'b1;
            ld_rx  = 1'b1;
            done_c = 1'b1;
          end
          OP_MVI: begin
            drv_imm = 1'b1;
            ld_rx   = 1'b1;
            done_c  = 1'b1;
          end
          OP_ALU: begin
            drv_en     = 1'b1;
            drv_sel_rx = 1'b1;
            ld_a       = 1'b1;
            state_nxt  = ST_T2;
          end
          OP_NOP: begin
            done_c = 1'b1;
          end
          default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            trap   = 1'b1;
`else
            done_c = 1'b1;
`endif
          end
        endcase
      end
      ST_T2: begin
        drv_en    = 1'b1;
        ld_g      = 1'b1;
        state_nxt = ST_T3;
      end
      ST_T3: begin
        drv_g     = 1'b1;
        ld_rx     = 1'b1;
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU T1 drives rx onto the bus; every other register-drive step uses ry
  assign drv_idx = drv_sel_rx ? ir_rx : ir_ry;

  onehot_dec u_rx_dec (
    .idx (ir_rx),
    .en  (ld_rx),
    .oh  (rx_oh)
  );

  onehot_dec u_drv_dec (
    .idx (drv_idx),
    .en  (drv_en),
    .oh  (drv_oh)
  );

  // Assemble the full-width enable vectors; unassigned bits stay 0
  always_comb begin
    r_en_OH                        = '0;
    r_en_OH[7:0]                   = rx_oh;
    r_en_OH[REG_G_IDX]             = ld_g;
    r_en_OH[REG_A_IDX]             = ld_a;
    tri_controller_OH              = '0;
    tri_controller_OH[7:0]         = drv_oh;
    tri_controller_OH[TRI_G_IDX]   = drv_g;
    tri_controller_OH[TRI_IMM_IDX] = drv_imm;
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)    err_q <= 1'b0;
    else if (trap) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign code    = {ir_alu, 4'b0000, ir_imm};
  assign address = addr_q;
  assign busy    = (state != ST_IDLE);
  assign done    = done_c;

endmodule
